// File: rtl/csr_access_initiator_pkg.sv
// Shared types and helpers for the CSR access initiator.
package csr_access_initiator_pkg;

  // Transaction phases of the initiator.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_ACK = 2'd2,
    RSP      = 2'd3
  } state_t;

  // Width of a counter that must be able to represent timeout_cycles.
  function automatic int timeout_cnt_width(input int timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/csr_access_initiator.sv
// CSR-side master: turns a valid/ready command stream into single-cycle
// CSR access pulses, waits for the matching ack (bounded by a timeout)
// and returns read data / status on a valid/ready response stream.
// Only one transaction is ever outstanding.
module csr_access_initiator
  import csr_access_initiator_pkg::*;
#(
  parameter int WORD_BIT_WIDTH      = 32,
  parameter int BYTE_ADDR_BIT_WIDTH = 8,
  parameter int TIMEOUT_CYCLES      = 16
) (
  input  logic                           i_clk,
  input  logic                           i_async_rst_n,
  // command stream
  input  logic                           i_cmd_valid,
  output logic                           o_cmd_ready,
  input  logic                           i_cmd_is_wr,
  input  logic [BYTE_ADDR_BIT_WIDTH-1:0] i_cmd_byte_addr,
  input  logic [WORD_BIT_WIDTH-1:0]      i_cmd_wr_data,
  input  logic [WORD_BIT_WIDTH-1:0]      i_cmd_wr_bit_en,
  // response stream
  output logic                           o_rsp_valid,
  input  logic                           i_rsp_ready,
  output logic                           o_rsp_is_wr,
  output logic                           o_rsp_timeout,
  output logic [WORD_BIT_WIDTH-1:0]      o_rsp_rd_data,
  // CSR slave port
  output logic                           o_csr_acc_req,
  output logic                           o_csr_acc_req_is_wr,
  output logic [BYTE_ADDR_BIT_WIDTH-1:0] o_csr_byte_addr,
  output logic [WORD_BIT_WIDTH-1:0]      o_csr_wr_data,
  output logic [WORD_BIT_WIDTH-1:0]      o_csr_wr_bit_en,
  input  logic                           i_csr_rd_ack,
  input  logic [WORD_BIT_WIDTH-1:0]      i_csr_rd_data,
  input  logic                           i_csr_wr_ack
);

  localparam int               CNT_W    = timeout_cnt_width(TIMEOUT_CYCLES);
  // Count value of the last WAIT_ACK cycle before giving up.
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;

  logic                           is_wr_q, is_wr_d;
  logic [BYTE_ADDR_BIT_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_BIT_WIDTH-1:0]      wr_data_q, wr_data_d;
  logic [WORD_BIT_WIDTH-1:0]      bit_en_q, bit_en_d;
  logic                           rsp_timeout_q, rsp_timeout_d;
  logic [WORD_BIT_WIDTH-1:0]      rsp_rd_data_q, rsp_rd_data_d;

  logic cmd_hs;
  logic ack_match;
  logic cnt_expired;

  assign o_cmd_ready = (state_q == IDLE);
  assign cmd_hs      = i_cmd_valid && o_cmd_ready;
  // Only the ack that matches the outstanding direction counts.
  assign ack_match   = is_wr_q ? i_csr_wr_ack : i_csr_rd_ack;
  assign cnt_expired = (cnt_q == CNT_TERM);

  // Next-state logic: acks outside WAIT_ACK never move the FSM.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE:     if (cmd_hs) state_d = REQ;
      REQ:      state_d = WAIT_ACK;
      WAIT_ACK: if (ack_match || cnt_expired) state_d = RSP;
      RSP:      if (i_rsp_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_async_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!i_async_rst_n) state_q <= IDLE;
    else                state_q <= state_d;
  end

  // Timeout counter: zeroed on the way into WAIT_ACK, +1 per waiting cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == REQ) begin
      cnt_d = '0;
    end else if (state_q == WAIT_ACK && !ack_match && !cnt_expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Timeout counter register.
  always_ff @(posedge i_clk or negedge i_async_rst_n) begin
    if (!i_async_rst_n) cnt_q <= '0;
    else                cnt_q <= cnt_d;
  end

  // Capture command at handshake and response at ack/timeout; ack wins
  // over a timeout that lands on the same cycle.
  always_comb begin
    is_wr_d       = is_wr_q;
    addr_d        = addr_q;
    wr_data_d     = wr_data_q;
    bit_en_d      = bit_en_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_rd_data_d = rsp_rd_data_q;
    if (cmd_hs) begin
      is_wr_d   = i_cmd_is_wr;
      addr_d    = i_cmd_byte_addr;
      wr_data_d = i_cmd_wr_data;
      bit_en_d  = i_cmd_wr_bit_en;
    end
    if (state_q == WAIT_ACK) begin
      if (ack_match) begin
        rsp_timeout_d = 1'b0;
        rsp_rd_data_d = is_wr_q ? '0 : i_csr_rd_data;
      end else if (cnt_expired) begin
        rsp_timeout_d = 1'b1;
        rsp_rd_data_d = '0;
      end
    end
  end

  // Command and response capture registers.
  always_ff @(posedge i_clk or negedge i_async_rst_n) begin
    if (!i_async_rst_n) begin
      is_wr_q       <= 1'b0;
      addr_q        <= '0;
      wr_data_q     <= '0;
      bit_en_q      <= '0;
      rsp_timeout_q <= 1'b0;
      rsp_rd_data_q <= '0;
    end else begin
      is_wr_q       <= is_wr_d;
      addr_q        <= addr_d;
      wr_data_q     <= wr_data_d;
      bit_en_q      <= bit_en_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_rd_data_q <= rsp_rd_data_d;
    end
  end

  assign o_csr_acc_req       = (state_q == REQ);
  assign o_csr_acc_req_is_wr = is_wr_q;
  assign o_csr_byte_addr     = addr_q;
  assign o_csr_wr_data       = wr_data_q;
  assign o_csr_wr_bit_en     = bit_en_q;

  assign o_rsp_valid         = (state_q == RSP);
  assign o_rsp_is_wr         = is_wr_q;
  assign o_rsp_timeout       = rsp_timeout_q;
  assign o_rsp_rd_data       = rsp_rd_data_q;

endmodule

// File: tb/tb_csr_access_initiator.sv
// Bench for csr_access_initiator: a behavioural CSR slave (bridge + RAM,
// selectable RAM output register or dead slave) answers requests, and a
// word-array reference model predicts every response.
module tb_csr_access_initiator;

  localparam int W  = 32;
  localparam int AW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_cmd_valid = 1'b0;
  logic          o_cmd_ready;
  logic          i_cmd_is_wr = 1'b0;
  logic [AW-1:0] i_cmd_byte_addr = '0;
  logic [W-1:0]  i_cmd_wr_data = '0;
  logic [W-1:0]  i_cmd_wr_bit_en = '0;
  logic          o_rsp_valid;
  logic          i_rsp_ready = 1'b0;
  logic          o_rsp_is_wr;
  logic          o_rsp_timeout;
  logic [W-1:0]  o_rsp_rd_data;
  logic          o_csr_acc_req;
  logic          o_csr_acc_req_is_wr;
  logic [AW-1:0] o_csr_byte_addr;
  logic [W-1:0]  o_csr_wr_data;
  logic [W-1:0]  o_csr_wr_bit_en;
  logic          i_csr_rd_ack;
  logic [W-1:0]  i_csr_rd_data;
  logic          i_csr_wr_ack;

  int n_vec = 0;
  int n_err = 0;

  // 0: bridge without RAM output register, 1: with output register, 2: dead
  int           slave_mode = 0;
  logic         stray_rd_ack = 1'b0;
  logic         stray_wr_ack = 1'b0;
  bit [W-1:0]   slave_ram [64];
  bit [W-1:0]   model_ram [64];
  logic         s1_rd = 1'b0, s1_wr = 1'b0, s2_rd = 1'b0, s2_wr = 1'b0;
  logic [W-1:0] s1_data = '0, s2_data = '0;
  logic [5:0]   s_idx;

  csr_access_initiator #(
    .WORD_BIT_WIDTH     (W),
    .BYTE_ADDR_BIT_WIDTH(AW),
    .TIMEOUT_CYCLES     (TO)
  ) dut (
    .i_clk              (clk),
    .i_async_rst_n      (rst_n),
    .i_cmd_valid        (i_cmd_valid),
    .o_cmd_ready        (o_cmd_ready),
    .i_cmd_is_wr        (i_cmd_is_wr),
    .i_cmd_byte_addr    (i_cmd_byte_addr),
    .i_cmd_wr_data      (i_cmd_wr_data),
    .i_cmd_wr_bit_en    (i_cmd_wr_bit_en),
    .o_rsp_valid        (o_rsp_valid),
    .i_rsp_ready        (i_rsp_ready),
    .o_rsp_is_wr        (o_rsp_is_wr),
    .o_rsp_timeout      (o_rsp_timeout),
    .o_rsp_rd_data      (o_rsp_rd_data),
    .o_csr_acc_req      (o_csr_acc_req),
    .o_csr_acc_req_is_wr(o_csr_acc_req_is_wr),
    .o_csr_byte_addr    (o_csr_byte_addr),
    .o_csr_wr_data      (o_csr_wr_data),
    .o_csr_wr_bit_en    (o_csr_wr_bit_en),
    .i_csr_rd_ack       (i_csr_rd_ack),
    .i_csr_rd_data      (i_csr_rd_data),
    .i_csr_wr_ack       (i_csr_wr_ack)
  );

  always #5 clk = ~clk;

  // Behavioural slave: never reset, so acks of an abandoned access still arrive.
  assign s_idx = o_csr_byte_addr[7:2];
  always @(posedge clk) begin
    s1_rd   <= o_csr_acc_req && !o_csr_acc_req_is_wr && slave_mode != 2;
    s1_wr   <= o_csr_acc_req && o_csr_acc_req_is_wr && slave_mode != 2;
    s1_data <= slave_ram[s_idx];
    if (o_csr_acc_req && o_csr_acc_req_is_wr && slave_mode != 2)
      slave_ram[s_idx] <= (slave_ram[s_idx] & ~o_csr_wr_bit_en) | (o_csr_wr_data & o_csr_wr_bit_en);
    s2_rd   <= s1_rd;
    s2_wr   <= s1_wr;
    s2_data <= s1_data;
  end

  assign i_csr_rd_ack  = ((slave_mode == 1) ? s2_rd : s1_rd) | stray_rd_ack;
  assign i_csr_wr_ack  = ((slave_mode == 1) ? s2_wr : s1_wr) | stray_wr_ack;
  assign i_csr_rd_data = (slave_mode == 1) ? s2_data : s1_data;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete transaction with expectations from the reference model.
  // stray_mis: pulse the non-matching ack during the first wait cycle.
  // ack_term : pulse the matching ack on the timeout terminal cycle (dead slave).
  task automatic run_txn(input bit is_wr, input logic [7:0] addr, input logic [31:0] data,
                         input logic [31:0] en, input int mode, input int hold,
                         input bit stray_mis, input bit ack_term);
    int         exp_lat, lat, extra_req, idx;
    bit         exp_to;
    logic [31:0] exp_rd;
    idx     = int'(addr[7:2]);
    exp_to  = (mode == 2) && !ack_term;
    exp_lat = (mode == 0) ? 2 : (mode == 1) ? 3 : TO + 1;
    exp_rd  = (!is_wr && mode != 2) ? model_ram[idx] : 32'h0;
    if (is_wr && mode != 2) model_ram[idx] = (model_ram[idx] & ~en) | (data & en);
    slave_mode = mode;

    @(negedge clk);
    check_bit("cmd_ready_idle", o_cmd_ready, 1'b1);
    i_cmd_valid     = 1'b1;
    i_cmd_is_wr     = is_wr;
    i_cmd_byte_addr = addr;
    i_cmd_wr_data   = data;
    i_cmd_wr_bit_en = en;
    @(posedge clk); #1;
    i_cmd_valid     = 1'b0;
    i_cmd_is_wr     = 1'($urandom);
    i_cmd_byte_addr = 8'($urandom);
    i_cmd_wr_data   = $urandom;
    i_cmd_wr_bit_en = $urandom;
    check_bit("acc_req_pulse", o_csr_acc_req, 1'b1);
    check_bit("cmd_ready_busy", o_cmd_ready, 1'b0);
    check_bit("csr_is_wr", o_csr_acc_req_is_wr, is_wr);
    check_word("csr_addr", 32'(o_csr_byte_addr), 32'(addr));
    check_word("csr_wr_data", o_csr_wr_data, data);
    check_word("csr_bit_en", o_csr_wr_bit_en, en);

    lat = 0;
    extra_req = 0;
    while (o_rsp_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (o_csr_acc_req) extra_req++;
      stray_rd_ack = 1'b0;
      stray_wr_ack = 1'b0;
      if (stray_mis && lat == 1) begin
        if (is_wr) stray_rd_ack = 1'b1;
        else       stray_wr_ack = 1'b1;
      end
      if (ack_term && lat == TO) begin
        if (is_wr) stray_wr_ack = 1'b1;
        else       stray_rd_ack = 1'b1;
      end
    end
    stray_rd_ack = 1'b0;
    stray_wr_ack = 1'b0;
    check_word("rsp_latency", lat, exp_lat);
    check_word("extra_acc_req", extra_req, 0);
    check_bit("rsp_is_wr", o_rsp_is_wr, is_wr);
    check_bit("rsp_timeout", o_rsp_timeout, exp_to);
    check_word("rsp_rd_data", o_rsp_rd_data, exp_rd);

    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_bit("hold_rsp_valid", o_rsp_valid, 1'b1);
      check_word("hold_rd_data", o_rsp_rd_data, exp_rd);
      check_bit("hold_timeout", o_rsp_timeout, exp_to);
      check_bit("hold_cmd_ready", o_cmd_ready, 1'b0);
      check_bit("hold_acc_req", o_csr_acc_req, 1'b0);
    end

    i_rsp_ready = 1'b1;
    @(posedge clk); #1;
    i_rsp_ready = 1'b0;
    check_bit("rsp_valid_drop", o_rsp_valid, 1'b0);
    check_bit("cmd_ready_back", o_cmd_ready, 1'b1);
  endtask

  initial begin
    int saw_rsp, saw_req;

    // Power-on reset: every registered output must read zero.
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_bit("rst_acc_req", o_csr_acc_req, 1'b0);
    check_bit("rst_rsp_valid", o_rsp_valid, 1'b0);
    check_bit("rst_rsp_timeout", o_rsp_timeout, 1'b0);
    check_word("rst_rsp_rd_data", o_rsp_rd_data, 32'h0);
    check_word("rst_csr_addr", 32'(o_csr_byte_addr), 32'h0);
    check_word("rst_csr_wr_data", o_csr_wr_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_bit("post_rst_cmd_ready", o_cmd_ready, 1'b1);

    // Directed: full write, read through RAM output register, partial write.
    run_txn(1'b1, 8'h04, 32'hDEADBEEF, 32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0);
    run_txn(1'b0, 8'h04, 32'h0, 32'h0, 1, 0, 1'b0, 1'b0);
    run_txn(1'b1, 8'h04, 32'h12345678, 32'h0000_FFFF, 0, 0, 1'b0, 1'b0);
    run_txn(1'b0, 8'h04, 32'h0, 32'h0, 0, 0, 1'b0, 1'b0);

    // Dead slave: timeouts for write and read, then normal traffic resumes.
    run_txn(1'b1, 8'h08, 32'hCAFEF00D, 32'hFFFF_FFFF, 2, 0, 1'b0, 1'b0);
    run_txn(1'b0, 8'h04, 32'h0, 32'h0, 2, 0, 1'b0, 1'b0);
    run_txn(1'b0, 8'h04, 32'h0, 32'h0, 0, 0, 1'b0, 1'b0);
    // Ack on the terminal count cycle beats the timeout.
    run_txn(1'b1, 8'h0C, 32'h0BAD_0BAD, 32'hFFFF_FFFF, 2, 0, 1'b0, 1'b1);

    // Back-pressure for 5 cycles with a stray write ack during the read wait.
    run_txn(1'b0, 8'h04, 32'h0, 32'h0, 1, 5, 1'b1, 1'b0);

    // Acks while idle are ignored.
    @(negedge clk);
    stray_rd_ack = 1'b1;
    stray_wr_ack = 1'b1;
    saw_rsp = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (o_rsp_valid) saw_rsp++;
    end
    stray_rd_ack = 1'b0;
    stray_wr_ack = 1'b0;
    check_word("idle_ack_rsp", saw_rsp, 0);
    check_bit("idle_ack_ready", o_cmd_ready, 1'b1);

    // Reset in the middle of WAIT_ACK; the late read ack lands after release.
    slave_mode = 1;
    @(negedge clk);
    i_cmd_valid     = 1'b1;
    i_cmd_is_wr     = 1'b0;
    i_cmd_byte_addr = 8'h04;
    @(posedge clk); #1;
    i_cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_bit("midrst_acc_req", o_csr_acc_req, 1'b0);
    check_word("midrst_addr", 32'(o_csr_byte_addr), 32'h0);
    check_bit("midrst_rsp_valid", o_rsp_valid, 1'b0);
    check_word("midrst_rd_data", o_rsp_rd_data, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    saw_rsp = 0;
    saw_req = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (o_rsp_valid) saw_rsp++;
      if (o_csr_acc_req) saw_req++;
    end
    check_word("after_rst_rsp", saw_rsp, 0);
    check_word("after_rst_req", saw_req, 0);
    run_txn(1'b0, 8'h04, 32'h0, 32'h0, 0, 0, 1'b0, 1'b0);

    // Randomized traffic over a small address window so reads hit writes.
    for (int t = 0; t < 30; t++) begin
      logic [7:0]  a;
      logic [31:0] en;
      a  = {2'b00, 4'($urandom), 2'($urandom)};
      en = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      run_txn(1'($urandom_range(0, 1)), a, $urandom, en, $urandom_range(0, 1),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
